// File: rtl/fx3_slave_fifo_responder.sv
// Receiving end of the FX3 slave-FIFO thread 0. It emulates a ring of DMA buffers
// and reports commits, free-buffer count and sticky sequence/protocol errors.
//
// state    | meaning
// S_IDLE   | stream not armed or no empty buffer; thread 0 not ready
// S_FILL   | accepting words into the current buffer
// S_COMMIT | buffer-switch latency after a commit, held COMMIT_CYCLES cycles
module fx3_slave_fifo_responder #(
  parameter int BUFFER_WORDS    = 1024,
  parameter int WATERMARK_WORDS = 6,
  parameter int NUM_BUFFERS     = 4,
  parameter int COMMIT_CYCLES   = 3,
  localparam int LEN_W  = $clog2(BUFFER_WORDS + 1),
  localparam int FREE_W = $clog2(NUM_BUFFERS + 1),
  localparam int TMR_W  = $clog2(COMMIT_CYCLES + 1)
) (
  input  logic              fx3_clock,
  input  logic              fx3_nReset,
  input  logic              streamEnable,
  input  logic              hostDrain,
  input  logic              checkEnable,
  input  logic              fx3_nWrite,
  input  logic              fx3_nShort,
  input  logic [15:0]       fx3_data,
  output logic              fx3_nReady,
  output logic              fx3_th0Ready,
  output logic              fx3_th0Watermark,
  output logic              commitStrobe,
  output logic              commitShort,
  output logic [LEN_W-1:0]  commitLength,
  output logic [FREE_W-1:0] freeBuffers,
  output logic [15:0]       commitCount,
  output logic              sequenceError,
  output logic              protocolError
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMMIT} state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [LEN_W-1:0]   word_count_q, word_count_d;
  logic               nshort_prev_q;
  logic               seeded_q, seeded_d;
  logic [15:0]        expect_q, expect_d;

  logic               nready_q, nready_d;
  logic               ready_q, ready_d;
  logic               wmark_q, wmark_d;
  logic               strobe_q, strobe_d;
  logic               short_q, short_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic [FREE_W-1:0]  free_q, free_d;
  logic [15:0]        count_q, count_d;
  logic               seq_err_q, seq_err_d;
  logic               prot_err_q, prot_err_d;

  logic               in_fill, accept, short_edge, full_commit, short_commit, commit;
  logic [LEN_W-1:0]   wc_inc;

  always_comb begin
    in_fill      = (state_q == S_FILL);
    accept       = in_fill && !fx3_nWrite && (word_count_q < LEN_W'(BUFFER_WORDS));
    short_edge   = nshort_prev_q && !fx3_nShort;
    wc_inc       = word_count_q + LEN_W'(accept);
    full_commit  = accept && (wc_inc == LEN_W'(BUFFER_WORDS));
    // A full buffer wins over a coincident short edge: one commit, not short.
    short_commit = in_fill && short_edge && !full_commit;
    commit       = full_commit || short_commit;

    state_d      = state_q;
    timer_d      = timer_q;
    word_count_d = commit ? '0 : wc_inc;
    case (state_q)
      S_IDLE: begin
        if (streamEnable && (free_q != '0)) state_d = S_FILL;
      end
      S_FILL: begin
        if (commit) begin
          state_d = S_COMMIT;
          timer_d = TMR_W'(COMMIT_CYCLES - 1);
        end else if (!streamEnable) begin
          state_d = S_IDLE;
        end
      end
      S_COMMIT: begin
        if (timer_q == '0) state_d = (streamEnable && (free_q != '0)) ? S_FILL : S_IDLE;
        else               timer_d = timer_q - TMR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    free_d = free_q;
    if (commit && !hostDrain)
      free_d = free_q - FREE_W'(1);
    else if (hostDrain && !commit && (free_q != FREE_W'(NUM_BUFFERS)))
      free_d = free_q + FREE_W'(1);

    prot_err_d = prot_err_q
               | (!fx3_nWrite && !accept)
               | (short_edge && !in_fill)
               | (hostDrain && !commit && (free_q == FREE_W'(NUM_BUFFERS)));

    seeded_d  = seeded_q;
    expect_d  = expect_q;
    seq_err_d = seq_err_q;
    if (!checkEnable) begin
      seeded_d = 1'b0;
    end else if (accept) begin
      if (seeded_q && (fx3_data != expect_q)) seq_err_d = 1'b1;
      seeded_d = 1'b1;
      expect_d = fx3_data + 16'd1;
    end

    nready_d = ~streamEnable;
    ready_d  = (state_d == S_FILL);
    // Watermark follows the word count with one cycle of latency.
    wmark_d  = (state_d == S_FILL) &&
               ((LEN_W'(BUFFER_WORDS) - word_count_q) > LEN_W'(WATERMARK_WORDS));
    strobe_d = commit;
    short_d  = commit ? short_commit : short_q;
    length_d = commit ? wc_inc : length_q;
    count_d  = count_q + 16'(commit);
  end

  always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
    if (!fx3_nReset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      word_count_q  <= '0;
      nshort_prev_q <= 1'b1;
      seeded_q      <= 1'b0;
      expect_q      <= '0;
      nready_q      <= 1'b1;
      ready_q       <= 1'b0;
      wmark_q       <= 1'b0;
      strobe_q      <= 1'b0;
      short_q       <= 1'b0;
      length_q      <= '0;
      free_q        <= FREE_W'(NUM_BUFFERS);
      count_q       <= '0;
      seq_err_q     <= 1'b0;
      prot_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      word_count_q  <= word_count_d;
      nshort_prev_q <= fx3_nShort;
      seeded_q      <= seeded_d;
      expect_q      <= expect_d;
      nready_q      <= nready_d;
      ready_q       <= ready_d;
      wmark_q       <= wmark_d;
      strobe_q      <= strobe_d;
      short_q       <= short_d;
      length_q      <= length_d;
      free_q        <= free_d;
      count_q       <= count_d;
      seq_err_q     <= seq_err_d;
      prot_err_q    <= prot_err_d;
    end
  end

  assign fx3_nReady       = nready_q;
  assign fx3_th0Ready     = ready_q;
  assign fx3_th0Watermark = wmark_q;
  assign commitStrobe     = strobe_q;
  assign commitShort      = short_q;
  assign commitLength     = length_q;
  assign freeBuffers      = free_q;
  assign commitCount      = count_q;
  assign sequenceError    = seq_err_q;
  assign protocolError    = prot_err_q;

endmodule
